// File: rtl/mandel_iter_sched.sv
// mandel_iter_sched: per-pixel Mandelbrot iteration sequencer driving a shared z^2+c step unit.
// Optional feature macro MANDEL_ABORT_EN adds an abort input and an aborted status output.
module mandel_iter_sched #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  c_re,
    input  logic [WIDTH-1:0]  c_im,
    input  logic [ITER_W-1:0] max_iter,
`ifdef MANDEL_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic              escaped,
    output logic              step_valid,
    output logic [WIDTH-1:0]  step_z_re,
    output logic [WIDTH-1:0]  step_z_im,
    output logic [WIDTH-1:0]  step_c_re,
    output logic [WIDTH-1:0]  step_c_im,
    input  logic              step_res_valid,
    input  logic [WIDTH-1:0]  step_res_re,
    input  logic [WIDTH-1:0]  step_res_im,
    input  logic              step_res_esc
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    logic [1:0]        r_state;
    logic [ITER_W-1:0] r_max;
    logic [ITER_W-1:0] r_iter;
    logic              r_esc;
    logic [WIDTH-1:0]  r_z_re;
    logic [WIDTH-1:0]  r_z_im;
    logic [WIDTH-1:0]  r_c_re;
    logic [WIDTH-1:0]  r_c_im;
    logic [ITER_W-1:0] w_next;
    logic              w_abort;
    assign w_next = r_iter + ITER_W'(1);
`ifdef MANDEL_ABORT_EN
    logic r_aborted;
    assign w_abort = abort;
    assign aborted = r_aborted;
    always_ff @(posedge clk) begin
        if (rst)
            r_aborted <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_aborted <= 1'b0;
        else if ((r_state == S_ISSUE || r_state == S_WAIT) && abort)
            r_aborted <= 1'b1;
    end
`else
    assign w_abort = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_max   <= '0;
            r_iter  <= '0;
            r_esc   <= 1'b0;
            r_z_re  <= '0;
            r_z_im  <= '0;
            r_c_re  <= '0;
            r_c_im  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_c_re  <= c_re;
                    r_c_im  <= c_im;
                    r_max   <= max_iter;
                    r_z_re  <= '0;
                    r_z_im  <= '0;
                    r_iter  <= '0;
                    r_esc   <= 1'b0;
                    r_state <= (max_iter == '0) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: r_state <= w_abort ? S_DONE : S_WAIT;
                S_WAIT: if (w_abort) begin
                    r_state <= S_DONE;
                end else if (step_res_valid) begin
                    r_z_re  <= step_res_re;
                    r_z_im  <= step_res_im;
                    r_iter  <= w_next;
                    r_esc   <= step_res_esc;
                    r_state <= (step_res_esc || w_next == r_max) ? S_DONE : S_ISSUE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign busy       = r_state != S_IDLE;
    assign done       = r_state == S_DONE;
    assign step_valid = r_state == S_ISSUE;
    assign iter_count = r_iter;
    assign escaped    = r_esc;
    assign step_z_re  = r_z_re;
    assign step_z_im  = r_z_im;
    assign step_c_re  = r_c_re;
    assign step_c_im  = r_c_im;
endmodule

// File: tb/tb_mandel_iter_sched.sv
// tb_mandel_iter_sched: directed table-driven bench for mandel_iter_sched with a latency-programmable step model.
// Build with MANDEL_ABORT_EN defined to also exercise the abort path.
module tb_mandel_iter_sched;
    localparam int W  = 16;
    localparam int IW = 8;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  c_re = '0;
    logic [W-1:0]  c_im = '0;
    logic [IW-1:0] max_iter = '0;
    logic          busy, done, escaped, step_valid;
    logic [IW-1:0] iter_count;
    logic [W-1:0]  step_z_re, step_z_im, step_c_re, step_c_im;
    logic          step_res_valid = 1'b0;
    logic [W-1:0]  step_res_re = '0;
    logic [W-1:0]  step_res_im = '0;
    logic          step_res_esc = 1'b0;
`ifdef MANDEL_ABORT_EN
    logic          abort = 1'b0;
    logic          aborted;
`endif
    mandel_iter_sched #(.WIDTH(W), .ITER_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .c_re(c_re), .c_im(c_im), .max_iter(max_iter),
`ifdef MANDEL_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .done(done), .iter_count(iter_count), .escaped(escaped),
        .step_valid(step_valid), .step_z_re(step_z_re), .step_z_im(step_z_im),
        .step_c_re(step_c_re), .step_c_im(step_c_im),
        .step_res_valid(step_res_valid), .step_res_re(step_res_re),
        .step_res_im(step_res_im), .step_res_esc(step_res_esc)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [IW-1:0] max_iter;
        logic [W-1:0]  c_re;
        logic [W-1:0]  c_im;
        int            lat;
        int            esc_at;
        bit            spur;
        bit            hold;
        int            exp_iter;
        bit            exp_esc;
        int            exp_cyc;
    } vec_t;
    vec_t vecs[10];
    int total = 0;
    int bad = 0;
    int m_lat, m_esc, m_pend, m_issues, m_results;
    bit m_spur;
    logic [W-1:0] m_cre, m_cim;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [W-1:0] rre(input int n);
        return 16'(n * 291 + 5);
    endfunction
    function automatic logic [W-1:0] rim(input int n);
        return 16'(32'h8000 ^ (n * 7));
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // step unit: response arrives lat+1 cycles after the issue cycle
    task automatic model;
        step_res_valid = 1'b0;
        step_res_esc   = m_spur;
        step_res_re    = '0;
        step_res_im    = '0;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_results++;
                step_res_valid = 1'b1;
                step_res_re    = rre(m_results);
                step_res_im    = rim(m_results);
                step_res_esc   = (m_results == m_esc);
            end
        end
        if (step_valid) begin
            m_issues++;
            chk("issue_z_re", step_z_re, m_issues == 1 ? 16'h0 : rre(m_issues - 1));
            chk("issue_z_im", step_z_im, m_issues == 1 ? 16'h0 : rim(m_issues - 1));
            chk("issue_c_re", step_c_re, m_cre);
            chk("issue_c_im", step_c_im, m_cim);
            m_pend = m_lat + 1;
            if (m_spur && !step_res_valid) begin
                step_res_valid = 1'b1;
                step_res_esc   = 1'b1;
                step_res_re    = 16'hDEAD;
                step_res_im    = 16'hBEEF;
            end
        end
    endtask
    task automatic run(input vec_t v);
        int cyc;
        bit seen;
        m_lat = v.lat; m_esc = v.esc_at; m_spur = v.spur;
        m_pend = 0; m_issues = 0; m_results = 0;
        m_cre = v.c_re; m_cim = v.c_im;
        c_re = v.c_re; c_im = v.c_im; max_iter = v.max_iter;
        start = 1'b1;
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            tick;
            cyc++;
            if (v.hold) begin
                c_re = ~v.c_re; c_im = ~v.c_im; max_iter = 8'd0;
            end else
                start = 1'b0;
            model;
            if (done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        chk("done_cycle", cyc, v.exp_cyc);
        chk("done_busy", busy, 1);
        chk("iter_count", iter_count, v.exp_iter);
        chk("escaped", escaped, v.exp_esc);
        chk("pulses", m_issues, v.exp_iter);
        chk("final_z_re", step_z_re, v.exp_iter == 0 ? 16'h0 : rre(v.exp_iter));
        start = 1'b0;
        c_re = v.c_re; c_im = v.c_im;
        tick;
        model;
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_iter", iter_count, v.exp_iter);
        chk("post_esc", escaped, v.exp_esc);
        chk("post_c_re", step_c_re, v.c_re);
        if (v.spur) begin
            step_res_valid = 1'b1;
            step_res_esc   = 1'b1;
            tick;
            chk("idle_spur_iter", iter_count, v.exp_iter);
            chk("idle_spur_busy", busy, 0);
        end
        m_spur = 1'b0;
        step_res_valid = 1'b0;
        step_res_esc = 1'b0;
    endtask
    initial begin
        vecs[0] = '{8'd16,  16'h0000, 16'h0000, 1, 0, 1'b0, 1'b0, 16,  1'b0, 50};
        vecs[1] = '{8'd100, 16'h1000, 16'hF000, 1, 3, 1'b0, 1'b0, 3,   1'b1, 11};
        vecs[2] = '{8'd0,   16'h0ABC, 16'h0DEF, 1, 0, 1'b0, 1'b0, 0,   1'b0, 2};
        vecs[3] = '{8'd1,   16'h0123, 16'h0456, 4, 0, 1'b0, 1'b0, 1,   1'b0, 8};
        vecs[4] = '{8'd5,   16'hE000, 16'h2000, 1, 5, 1'b0, 1'b0, 5,   1'b1, 17};
        vecs[5] = '{8'd255, 16'h0001, 16'hFFFF, 1, 0, 1'b0, 1'b0, 255, 1'b0, 767};
        vecs[6] = '{8'd4,   16'h1111, 16'h2222, 1, 0, 1'b0, 1'b1, 4,   1'b0, 14};
        vecs[7] = '{8'd2,   16'h3333, 16'h4444, 2, 0, 1'b1, 1'b0, 2,   1'b0, 10};
        vecs[8] = '{8'd3,   16'h5555, 16'h6666, 3, 0, 1'b0, 1'b0, 3,   1'b0, 17};
        vecs[9] = '{8'd0,   16'h7777, 16'h8888, 1, 0, 1'b0, 1'b1, 0,   1'b0, 2};
        m_spur = 1'b0; m_pend = 0; m_lat = 1; m_esc = 0; m_issues = 0; m_results = 0;
        rst = 1'b1; start = 1'b1; max_iter = 8'd5; c_re = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_iter", iter_count, 0);
            chk("rst_step_valid", step_valid, 0);
            chk("rst_c_re", step_c_re, 0);
        end
        rst = 1'b0; start = 1'b0;
        tick;
        for (int i = 0; i < 10; i++) run(vecs[i]);
        m_lat = 3; m_esc = 0; m_pend = 0; m_issues = 0; m_results = 0;
        m_cre = 16'h0ABC; m_cim = 16'h0CBA;
        c_re = m_cre; c_im = m_cim; max_iter = 8'd10; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            start = 1'b0;
            model;
        end
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            model;
            chk("wrst_busy", busy, 0);
            chk("wrst_done", done, 0);
            chk("wrst_iter", iter_count, 0);
            chk("wrst_step_valid", step_valid, 0);
            chk("wrst_z_re", step_z_re, 0);
            tick;
        end
`ifdef MANDEL_ABORT_EN
        m_lat = 1; m_esc = 0; m_pend = 0; m_issues = 0; m_results = 0;
        m_cre = 16'h0400; m_cim = 16'h0200;
        c_re = m_cre; c_im = m_cim; max_iter = 8'd64; start = 1'b1;
        for (int i = 0; i < 100 && m_results < 5; i++) begin
            tick;
            start = 1'b0;
            model;
        end
        chk("ab_results", m_results, 5);
        tick; model;
        chk("ab_issue", step_valid, 1);
        tick; model;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        model;
        chk("ab_done", done, 1);
        chk("ab_aborted", aborted, 1);
        chk("ab_escaped", escaped, 0);
        chk("ab_iter", iter_count, 5);
        tick; model;
        chk("ab_idle_busy", busy, 0);
        chk("ab_held", aborted, 1);
        max_iter = 8'd0; start = 1'b1;
        tick;
        start = 1'b0;
        chk("ab_cleared", aborted, 0);
        tick;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mandel_iter_sched.md
Name: mandel_iter_sched

Overview:
Per-pixel iteration sequencer for the Mandelbrot accelerator. Accepts one point c = (c_re, c_im) and an iteration limit, then drives the shared z^2+c step datapath one iteration at a time over a valid/response handshake. Counts iterations and stops on escape or at the limit. Reports the result to the pixel/readout logic behind the top-level tt_um_mandelbrot_accel.

Parameters:
WIDTH, 16, fixed-point operand width (signed Q4.12; 1.0 = 0x1000)
ITER_W, 8, width of iteration limit and counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a point; sampled only in IDLE
c_re  in  WIDTH  real part of c; latched on accepted start
c_im  in  WIDTH  imag part of c; latched on accepted start
max_iter  in  ITER_W  iteration limit; latched on accepted start
busy  out  1  high from the cycle after an accepted start until DONE exits
done  out  1  one-cycle pulse when result is valid
iter_count  out  ITER_W  iterations completed; valid from done, held until next accepted start
escaped  out  1  1 = step unit flagged escape; held with iter_count
step_valid  out  1  one-cycle issue strobe to step datapath
step_z_re  out  WIDTH  current z real, stable while busy between updates
step_z_im  out  WIDTH  current z imag
step_c_re  out  WIDTH  latched c real
step_c_im  out  WIDTH  latched c imag
step_res_valid  in  1  step datapath result strobe (any latency >= 1 cycle)
step_res_re  in  WIDTH  next z real
step_res_im  in  WIDTH  next z imag
step_res_esc  in  1  escape flag for this result

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset: state=IDLE; every output 0 (busy, done, iter_count, escaped, step_valid, step_z_*, step_c_*). Reset mid-operation aborts the point with no done pulse. Late step_res_valid pulses are ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On start=1: latch c_re/c_im/max_iter; z<=0; iter_count<=0; escaped<=0; busy<=1.
  - If max_iter==0, go to DONE; otherwise go to ISSUE.
- ISSUE: step_valid=1 for exactly this cycle; go to WAIT.
- WAIT: hold z. On step_res_valid=1:
  - z<=step_res_*; iter_count<=iter_count+1.
  - If step_res_esc: escaped<=1, go to DONE.
  - Else if iter_count+1==max_iter: go to DONE.
  - Else go to ISSUE.
- DONE: done=1 for one cycle; busy<=0; go to IDLE. iter_count and escaped are held until the next accepted start.
- Ignored inputs:
  - start while not in IDLE, including the DONE cycle.
  - step_res_valid outside WAIT.
  - step_res_esc without step_res_valid.
- Escape and limit in the same response: escaped=1 wins.
- Counter never wraps: max_iter=2^ITER_W-1 ends at that value.
- Throughput: 2 + step latency cycles per iteration. For a 1-cycle step unit, start to done = 3*N+2 cycles when no escape occurs.
- No arithmetic on z or c in this block; values pass through unmodified.

Optional Feature:
MANDEL_ABORT_EN
- Defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in ISSUE or WAIT: go to DONE next cycle with escaped=0, aborted=1, iter_count holding completed iterations.
  - An abort in the same cycle as step_res_valid discards that result.
  - aborted is cleared on the next accepted start.
  - abort in IDLE/DONE is ignored.
- Undefined: abort and aborted ports are absent; behaviour as above.

Test Plan:
- Reset hold: rst=1 for 3 cycles with start=1 -> busy=0, done=0, iter_count=0, step_valid=0 throughout.
- Bound point: c=(0x0000,0x0000), max_iter=16, 1-cycle model, never escapes -> 16 step_valid pulses, done at cycle 50, iter_count=16, escaped=0.
- Escape: max_iter=100, model asserts step_res_esc on 3rd result -> done, iter_count=3, escaped=1, exactly 3 step_valid pulses. Check step_z_* equals the 2nd result during the 3rd issue.
- Edge limits and variable latency:
  - max_iter=0 -> done 2 cycles after start, iter_count=0, no step_valid.
  - max_iter=1 with 4-cycle model latency -> iter_count=1.
  - Escape and limit in the same result -> escaped=1.
- Protocol abuse:
  - start pulses while busy and in the DONE cycle -> ignored, latched c unchanged.
  - Spurious step_res_valid during ISSUE/IDLE -> no count change.
  - rst asserted in WAIT -> IDLE, outputs 0, no done.
- MANDEL_ABORT_EN: abort in WAIT after 5 results, max_iter=64 -> done next cycle, aborted=1, escaped=0, iter_count=5. Next start clears aborted.
